bf_sram_responder: RTL

// - Responder end of the bloom-filter SRAM request interface.
// - Queues the initiator's rd_0/wr_0 request pulses and serves them one access per cycle,
//   in arrival order, against a zero-initialised single-port array.
// - Returns ack/vld/data with fixed timing; stands in for the external 72-bit SRAM in sim and on-chip builds.

---
 rtl/bf_sram_responder_pkg.sv | 18 +
 rtl/bf_sram_array.sv | 27 ++
 rtl/bf_sram_responder.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/bf_sram_responder_pkg.sv
// Shared definitions for the bloom-filter SRAM responder: default widths,
// FSM state encoding and the request sequence-tag width helper.
package bf_sram_responder_pkg;

  localparam int DEF_DATA_WIDTH      = 72;
  localparam int DEF_SRAM_ADDR_WIDTH = 18;

  typedef enum logic [0:0] {
    BFS_INIT = 1'b0,
    BFS_RUN  = 1'b1
  } bfs_state_e;

  // Two extra bits keep the wrap-aware age comparison unambiguous.
  function automatic int seq_width(input int fifo_depth_bits);
    return fifo_depth_bits + 2;
  endfunction

endpackage

// File: rtl/bf_sram_array.sv
// Single-port synchronous RAM: one read or write per cycle, registered read
// data, contents are never reset.
module bf_sram_array #(
  parameter int DATA_WIDTH = 72,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  en,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [1 << ADDR_WIDTH];

  always_ff @(posedge clk) begin
    if (en && we) mem[addr] <= wdata;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)         rdata <= '0;
    else if (en && !we)   rdata <= mem[addr];
  end

endmodule

// File: rtl/bf_sram_responder.sv
// Responder end of the bloom-filter SRAM request interface: queues read/write
// request pulses and serves them one array access per cycle in arrival order.
module bf_sram_responder
  import bf_sram_responder_pkg::*;
#(
  parameter int DATA_WIDTH      = DEF_DATA_WIDTH,
  parameter int SRAM_ADDR_WIDTH = DEF_SRAM_ADDR_WIDTH,
  parameter int MEM_DEPTH_BITS  = 10,
  parameter int RD_LATENCY      = 3,
  parameter int FIFO_DEPTH_BITS = 3
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       rd_0_req,
  input  logic [SRAM_ADDR_WIDTH-1:0] rd_0_addr,
  output logic                       rd_0_ack,
  output logic                       rd_0_vld,
  output logic [DATA_WIDTH-1:0]      rd_0_data,
  input  logic                       wr_0_req,
  input  logic [SRAM_ADDR_WIDTH-1:0] wr_0_addr,
  input  logic [DATA_WIDTH-1:0]      wr_0_data,
  output logic                       wr_0_ack,
  output logic                       rd_fifo_nearly_full,
  output logic                       wr_fifo_nearly_full,
  output logic                       init_done,
  output logic                       req_overflow,
  output bfs_state_e                 fsm_state
);

  // Handshake: req is a one-cycle fire-and-forget pulse (no ready); the
  // initiator throttles on *_nearly_full. ack marks the cycle the request is
  // served; rd_0_vld/rd_0_data follow rd_0_ack by exactly RD_LATENCY cycles.

  localparam int SW = seq_width(FIFO_DEPTH_BITS);
  localparam int QD = 1 << FIFO_DEPTH_BITS;
  localparam int CW = FIFO_DEPTH_BITS + 1;
  localparam int MW = MEM_DEPTH_BITS;
  localparam logic [CW-1:0] Q_FULL   = CW'(QD);
  localparam logic [CW-1:0] Q_NEARLY = CW'(QD - 1);

  bfs_state_e    state;
  logic [MW-1:0] init_addr;
  logic [SW-1:0] seq;

  logic [SW-1:0]              rq_seq [QD];
  logic [MW-1:0]              rq_idx [QD];
  logic [FIFO_DEPTH_BITS-1:0] rq_wptr, rq_rptr;
  logic [CW-1:0]              rq_cnt;

  logic [SW-1:0]              wq_seq  [QD];
  logic [MW-1:0]              wq_idx  [QD];
  logic [DATA_WIDTH-1:0]      wq_data [QD];
  logic [FIFO_DEPTH_BITS-1:0] wq_wptr, wq_rptr;
  logic [CW-1:0]              wq_cnt;

  logic rq_full, rq_empty, wq_full, wq_empty;
  logic rd_pop, wr_pop, rd_push, wr_push, rd_drop, wr_drop;
  logic [SW-1:0] age;

  logic                  ram_en, ram_we;
  logic [MW-1:0]         ram_addr;
  logic [DATA_WIDTH-1:0] ram_wdata, ram_rdata;

  // Address bits above the array index alias by design.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{rd_0_addr[SRAM_ADDR_WIDTH-1:MW], wr_0_addr[SRAM_ADDR_WIDTH-1:MW]};

  assign rq_full  = (rq_cnt == Q_FULL);
  assign rq_empty = (rq_cnt == '0);
  assign wq_full  = (wq_cnt == Q_FULL);
  assign wq_empty = (wq_cnt == '0);

  assign rd_fifo_nearly_full = (rq_cnt >= Q_NEARLY);
  assign wr_fifo_nearly_full = (wq_cnt >= Q_NEARLY);

  // Older head wins; a tie goes to the read so it sees pre-write data.
  always_comb begin
    rd_pop = 1'b0;
    wr_pop = 1'b0;
    age    = rq_seq[rq_rptr] - wq_seq[wq_rptr];
    if (state == BFS_RUN) begin
      if (!rq_empty && !wq_empty) begin
        if (age[SW-1] || (age == '0)) rd_pop = 1'b1;
        else                          wr_pop = 1'b1;
      end else if (!rq_empty) begin
        rd_pop = 1'b1;
      end else if (!wq_empty) begin
        wr_pop = 1'b1;
      end
    end
  end

  assign rd_push = rd_0_req && (!rq_full || rd_pop);
  assign wr_push = wr_0_req && (!wq_full || wr_pop);
  assign rd_drop = rd_0_req && rq_full && !rd_pop;
  assign wr_drop = wr_0_req && wq_full && !wr_pop;

  assign rd_0_ack  = rd_pop;
  assign wr_0_ack  = wr_pop;
  assign fsm_state = state;

  always_ff @(posedge clk) begin
    if (rd_push) begin
      rq_seq[rq_wptr] <= seq;
      rq_idx[rq_wptr] <= rd_0_addr[MW-1:0];
    end
    if (wr_push) begin
      wq_seq[wq_wptr]  <= seq;
      wq_idx[wq_wptr]  <= wr_0_addr[MW-1:0];
      wq_data[wq_wptr] <= wr_0_data;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rq_wptr      <= '0;
      rq_rptr      <= '0;
      rq_cnt       <= '0;
      wq_wptr      <= '0;
      wq_rptr      <= '0;
      wq_cnt       <= '0;
      seq          <= '0;
      req_overflow <= 1'b0;
    end else begin
      if (rd_push) rq_wptr <= rq_wptr + 1'b1;
      if (rd_pop)  rq_rptr <= rq_rptr + 1'b1;
      if (rd_push && !rd_pop)      rq_cnt <= rq_cnt + 1'b1;
      else if (!rd_push && rd_pop) rq_cnt <= rq_cnt - 1'b1;
      if (wr_push) wq_wptr <= wq_wptr + 1'b1;
      if (wr_pop)  wq_rptr <= wq_rptr + 1'b1;
      if (wr_push && !wr_pop)      wq_cnt <= wq_cnt + 1'b1;
      else if (!wr_push && wr_pop) wq_cnt <= wq_cnt - 1'b1;
      if (rd_push || wr_push) seq <= seq + 1'b1;
      if (rd_drop || wr_drop) req_overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= BFS_INIT;
      init_addr <= '0;
      init_done <= 1'b0;
    end else begin
      case (state)
        BFS_INIT: begin
          init_addr <= init_addr + 1'b1;
          if (init_addr == '1) begin
            state     <= BFS_RUN;
            init_done <= 1'b1;
          end
        end
        BFS_RUN: state <= BFS_RUN;
        default: state <= BFS_INIT;
      endcase
    end
  end

  always_comb begin
    ram_en    = 1'b0;
    ram_we    = 1'b0;
    ram_addr  = init_addr;
    ram_wdata = '0;
    if (state == BFS_INIT) begin
      ram_en = 1'b1;
      ram_we = 1'b1;
    end else if (wr_pop) begin
      ram_en    = 1'b1;
      ram_we    = 1'b1;
      ram_addr  = wq_idx[wq_rptr];
      ram_wdata = wq_data[wq_rptr];
    end else if (rd_pop) begin
      ram_en   = 1'b1;
      ram_addr = rq_idx[rq_rptr];
    end
  end

  bf_sram_array #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (MW)
  ) u_array (
    .clk     (clk),
    .reset_n (reset_n),
    .en      (ram_en),
    .we      (ram_we),
    .addr    (ram_addr),
    .wdata   (ram_wdata),
    .rdata   (ram_rdata)
  );

  // The array output register is the first latency stage.
  if (RD_LATENCY == 1) begin : g_lat1
    logic vld_q;
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) vld_q <= 1'b0;
      else          vld_q <= rd_pop;
    end
    assign rd_0_vld  = vld_q;
    assign rd_0_data = ram_rdata;
  end else begin : g_latn
    logic [RD_LATENCY-1:0] vld_sr;
    logic [DATA_WIDTH-1:0] data_sr [RD_LATENCY-1];
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        vld_sr <= '0;
        for (int i = 0; i < RD_LATENCY - 1; i++) data_sr[i] <= '0;
      end else begin
        vld_sr     <= {vld_sr[RD_LATENCY-2:0], rd_pop};
        data_sr[0] <= ram_rdata;
        for (int i = 1; i < RD_LATENCY - 1; i++) data_sr[i] <= data_sr[i-1];
      end
    end
    assign rd_0_vld  = vld_sr[RD_LATENCY-1];
    assign rd_0_data = data_sr[RD_LATENCY-2];
  end

endmodule
